// File: rtl/alu_seq.sv
// Multi-cycle ALU: single-cycle logic/arithmetic plus iterative unsigned multiply behind a
// start/busy/done handshake. Define ALU_SEQ_DIV_EN to add the iterative unsigned divider (op 100).
module alu_seq #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] hi,
    output logic             zero,
    output logic             err,
    output logic             busy,
    output logic             done
);

    localparam int unsigned CntW = $clog2(WIDTH + 1);
    localparam logic [CntW-1:0] CntInit = CntW'(WIDTH);
    localparam logic [CntW-1:0] CntOne  = CntW'(1);

    localparam logic [2:0] OpAnd  = 3'b000;
    localparam logic [2:0] OpOr   = 3'b001;
    localparam logic [2:0] OpAdd  = 3'b010;
    localparam logic [2:0] OpMul  = 3'b011;
    localparam logic [2:0] OpDivu = 3'b100;
    localparam logic [2:0] OpSub  = 3'b110;
    localparam logic [2:0] OpSlt  = 3'b111;

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e           state_q, state_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0] acc_q, acc_d;     // product high half / partial remainder
    logic [WIDTH-1:0] lo_q, lo_d;       // multiplier shifting out / quotient shifting in
    logic [WIDTH-1:0] opnd_q, opnd_d;   // multiplicand or divisor
    logic [WIDTH-1:0] result_q, result_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic             zero_q, zero_d;
    logic             err_q, err_d;
`ifdef ALU_SEQ_DIV_EN
    logic             run_div_q, run_div_d;
`endif

    // Single-cycle datapath, computed straight from the inputs sampled with start.
    logic [WIDTH-1:0] sc_result, sc_hi;
    logic             sc_err, sc_iter;

    always_comb begin
        sc_result = '0;
        sc_hi     = '0;
        sc_err    = 1'b0;
        sc_iter   = 1'b0;
        unique case (op)
            OpAnd: sc_result = a & b;
            OpOr:  sc_result = a | b;
            OpAdd: sc_result = a + b;
            OpSub: sc_result = a - b;
            OpSlt: sc_result = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OpMul: sc_iter   = 1'b1;
            OpDivu: begin
`ifdef ALU_SEQ_DIV_EN
                if (b == '0) begin
                    sc_result = '1;
                    sc_hi     = a;
                    sc_err    = 1'b1;
                end else begin
                    sc_iter = 1'b1;
                end
`else
                sc_err = 1'b1;
`endif
            end
            default: sc_err = 1'b1;
        endcase
    end

    // One shift-add multiply step: add multiplicand when the multiplier LSB is set, shift right.
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH-1:0] mul_acc, mul_lo;

    always_comb begin
        mul_sum = {1'b0, acc_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
        mul_acc = mul_sum[WIDTH:1];
        mul_lo  = {mul_sum[0], lo_q[WIDTH-1:1]};
    end

    logic [WIDTH-1:0] step_acc, step_lo;

`ifdef ALU_SEQ_DIV_EN
    // One restoring divide step; a clear MSB of the difference means the subtract fits.
    logic [WIDTH:0] div_shift, div_diff;

    always_comb begin
        div_shift = {acc_q, lo_q[WIDTH-1]};
        div_diff  = div_shift - {1'b0, opnd_q};
        if (run_div_q) begin
            if (!div_diff[WIDTH]) begin
                step_acc = div_diff[WIDTH-1:0];
                step_lo  = {lo_q[WIDTH-2:0], 1'b1};
            end else begin
                step_acc = div_shift[WIDTH-1:0];
                step_lo  = {lo_q[WIDTH-2:0], 1'b0};
            end
        end else begin
            step_acc = mul_acc;
            step_lo  = mul_lo;
        end
    end
`else
    always_comb begin
        step_acc = mul_acc;
        step_lo  = mul_lo;
    end
`endif

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        lo_d     = lo_q;
        opnd_d   = opnd_q;
        result_d = result_q;
        hi_d     = hi_q;
        zero_d   = zero_q;
        err_d    = err_q;
`ifdef ALU_SEQ_DIV_EN
        run_div_d = run_div_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    if (sc_iter) begin
                        state_d = StRun;
                        cnt_d   = CntInit;
                        acc_d   = '0;
`ifdef ALU_SEQ_DIV_EN
                        run_div_d = (op == OpDivu);
                        lo_d      = (op == OpDivu) ? a : b;
                        opnd_d    = (op == OpDivu) ? b : a;
`else
                        lo_d   = b;
                        opnd_d = a;
`endif
                    end else begin
                        state_d  = StDone;
                        result_d = sc_result;
                        hi_d     = sc_hi;
                        zero_d   = (sc_result == '0);
                        err_d    = sc_err;
                    end
                end
            end
            StRun: begin
                acc_d = step_acc;
                lo_d  = step_lo;
                cnt_d = cnt_q - CntOne;
                if (cnt_q == CntOne) begin
                    state_d  = StDone;
                    result_d = step_lo;
                    hi_d     = step_acc;
                    zero_d   = (step_lo == '0);
                    err_d    = 1'b0;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            acc_q    <= '0;
            lo_q     <= '0;
            opnd_q   <= '0;
            result_q <= '0;
            hi_q     <= '0;
            zero_q   <= 1'b1;
            err_q    <= 1'b0;
`ifdef ALU_SEQ_DIV_EN
            run_div_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            lo_q     <= lo_d;
            opnd_q   <= opnd_d;
            result_q <= result_d;
            hi_q     <= hi_d;
            zero_q   <= zero_d;
            err_q    <= err_d;
`ifdef ALU_SEQ_DIV_EN
            run_div_q <= run_div_d;
`endif
        end
    end

    assign result = result_q;
    assign hi     = hi_q;
    assign zero   = zero_q;
    assign err    = err_q;
    assign busy   = (state_q != StIdle);
    assign done   = (state_q == StDone);

endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq (WIDTH=32); divider vectors run only when
// ALU_SEQ_DIV_EN is defined, otherwise op 100 is checked as illegal.
module tb_alu_seq;

    localparam int unsigned W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [2:0]   op;
    logic [W-1:0] a, b;
    logic [W-1:0] result, hi;
    logic         zero, err, busy, done;

    int total  = 0;
    int passed = 0;
    int failed = 0;
    int cyc;
    int done_seen;

    always #5 clk = ~clk;

    alu_seq #(.WIDTH(W)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .result (result),
        .hi     (hi),
        .zero   (zero),
        .err    (err),
        .busy   (busy),
        .done   (done)
    );

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            failed++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive one start pulse; returns 1 ns into cycle 1 (the cycle after the accepting edge).
    task automatic issue(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        op    = o;
        a     = x;
        b     = y;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        op    = 3'b000;
        a     = '0;
        b     = '0;
        tick();
        tick();
        check("rst_result", result, 32'h0);
        check("rst_hi", hi, 32'h0);
        check("rst_zero", 32'(zero), 32'd1);
        check("rst_err", 32'(err), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        reset = 1'b0;
        tick();

        issue(3'b000, 32'hF0F0_1234, 32'h0FF0_FF00);
        check("and_done", 32'(done), 32'd1);
        check("and_result", result, 32'h00F0_1200);
        tick();
        check("and_idle", 32'(busy), 32'd0);

        issue(3'b001, 32'hF000_0001, 32'h0000_0F00);
        check("or_result", result, 32'hF000_0F01);
        tick();

        issue(3'b010, 32'hFFFF_FFFF, 32'h1);
        check("add_wrap_done", 32'(done), 32'd1);
        check("add_wrap_result", result, 32'h0);
        check("add_wrap_zero", 32'(zero), 32'd1);
        check("add_wrap_hi", hi, 32'h0);
        check("add_wrap_err", 32'(err), 32'd0);
        tick();

        issue(3'b111, 32'h8000_0000, 32'h1);
        check("slt_neg", result, 32'h1);
        tick();
        issue(3'b111, 32'h1, 32'h8000_0000);
        check("slt_swap", result, 32'h0);
        check("slt_swap_zero", 32'(zero), 32'd1);
        tick();

        issue(3'b110, 32'd3, 32'd5);
        check("sub_result", result, 32'hFFFF_FFFE);
        check("sub_zero", 32'(zero), 32'd0);
        tick();

        // MUL 0xFFFFFFFF^2 with a stray start in RUN; outputs must hold the SUB result meanwhile
        issue(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        check("mul_busy", 32'(busy), 32'd1);
        check("mul_nodone", 32'(done), 32'd0);
        cyc = 1;
        while (!done && cyc < 100) begin
            if (cyc == 5) begin
                op    = 3'b010;
                a     = 32'd1;
                b     = 32'd1;
                start = 1'b1;
            end
            tick();
            start = 1'b0;
            cyc++;
            if (cyc == 10) begin
                check("mul_hold_result", result, 32'hFFFF_FFFE);
                check("mul_hold_busy", 32'(busy), 32'd1);
            end
        end
        check("mul_latency", 32'(cyc), 32'd33);
        check("mul_hi", hi, 32'hFFFF_FFFE);
        check("mul_result", result, 32'h0000_0001);
        check("mul_err", 32'(err), 32'd0);
        tick();
        check("mul_done_pulse", 32'(done), 32'd0);
        check("mul_busy_fall", 32'(busy), 32'd0);

        issue(3'b011, 32'd12345, 32'd0);
        cyc = 1;
        while (!done && cyc < 100) begin
            tick();
            cyc++;
        end
        check("mul0_latency", 32'(cyc), 32'd33);
        check("mul0_result", result, 32'h0);
        check("mul0_zero", 32'(zero), 32'd1);
        tick();

        // Illegal op, then ADD accepted in the very next IDLE cycle
        issue(3'b101, 32'd9, 32'd9);
        check("ill_done", 32'(done), 32'd1);
        check("ill_err", 32'(err), 32'd1);
        check("ill_result", result, 32'h0);
        check("ill_zero", 32'(zero), 32'd1);
        tick();
        issue(3'b010, 32'd2, 32'd3);
        check("b2b_done", 32'(done), 32'd1);
        check("b2b_result", result, 32'd5);
        check("b2b_err", 32'(err), 32'd0);
        tick();

`ifdef ALU_SEQ_DIV_EN
        issue(3'b100, 32'd100, 32'd7);
        cyc = 1;
        while (!done && cyc < 100) begin
            tick();
            cyc++;
        end
        check("div_latency", 32'(cyc), 32'd33);
        check("div_quot", result, 32'd14);
        check("div_rem", hi, 32'd2);
        check("div_err", 32'(err), 32'd0);
        tick();

        issue(3'b100, 32'hDEAD_BEEF, 32'd0);
        check("div0_done", 32'(done), 32'd1);
        check("div0_result", result, 32'hFFFF_FFFF);
        check("div0_hi", hi, 32'hDEAD_BEEF);
        check("div0_err", 32'(err), 32'd1);
        tick();
`else
        issue(3'b100, 32'd100, 32'd7);
        check("divoff_done", 32'(done), 32'd1);
        check("divoff_err", 32'(err), 32'd1);
        check("divoff_result", result, 32'h0);
        tick();
`endif

        // Reset in RUN cycle 3 of MUL 5x7, after a nonzero result is on the outputs
        issue(3'b010, 32'd2, 32'd3);
        tick();
        check("pre_rst_result", result, 32'd5);
        issue(3'b011, 32'd5, 32'd7);
        tick();
        tick();
        reset = 1'b1;
        #1;
        check("midrst_result", result, 32'h0);
        check("midrst_hi", hi, 32'h0);
        check("midrst_zero", 32'(zero), 32'd1);
        check("midrst_err", 32'(err), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        tick();
        reset = 1'b0;
        done_seen = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (done) done_seen++;
        end
        check("midrst_no_done", 32'(done_seen), 32'd0);
        check("midrst_idle", 32'(busy), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
